// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/response bus between the MEM stage and memory
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_pc;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_pc,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_pc,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator with alignment check and bus timeout
module mem_access_unit #(
  parameter int MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [2:0]          op,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  input  logic [31:0]         pc,
  output logic                stall,
  output logic                done,
  output logic [31:0]         rdata,
  output logic                exc,
  output logic [4:0]          exc_code,
  mem_access_unit_if.master   mem
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        done_q, done_d, exc_q, exc_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, mem_pc_q, mem_pc_d;

  logic        is_store, is_word, is_half, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc, lane, load_val;

  always_comb begin
    is_store   = (op >= 3'd5);
    is_word    = (op == 3'd0) || (op == 3'd5);
    is_half    = (op == 3'd3) || (op == 3'd4) || (op == 3'd7);
    misaligned = is_word ? (addr[1:0] != 2'b00) : (is_half ? addr[0] : 1'b0);

    if (is_word)      be_calc = 4'b1111;
    else if (is_half) be_calc = 4'b0011 << {addr[1], 1'b0};
    else              be_calc = 4'b0001 << addr[1:0];

    case (op)
      3'd5:    wd_calc = wdata;
      3'd6:    wd_calc = {4{wdata[7:0]}};
      3'd7:    wd_calc = {2{wdata[15:0]}};
      default: wd_calc = 32'd0;
    endcase

    // The latched byte offset moves the addressed lane down to bit 0 before extension.
    lane = mem.mem_rdata >> {off_q, 3'b000};
    case (op_q)
      3'd0:    load_val = mem.mem_rdata;
      3'd1:    load_val = {{24{lane[7]}}, lane[7:0]};
      3'd2:    load_val = {24'd0, lane[7:0]};
      3'd3:    load_val = {{16{lane[15]}}, lane[15:0]};
      3'd4:    load_val = {16'd0, lane[15:0]};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    done_d      = done_q;
    exc_d       = exc_q;
    exc_code_d  = exc_code_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_pc_d    = mem_pc_q;

    case (state_q)
      IDLE: begin
        if (valid) begin
          if (misaligned) begin
            state_d    = DONE;
            done_d     = 1'b1;
            exc_d      = 1'b1;
            exc_code_d = is_store ? 5'd5 : 5'd4;
            rdata_d    = 32'd0;
          end else begin
            state_d     = BUSY;
            cnt_d       = '0;
            op_d        = op;
            off_d       = addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_be_d    = be_calc;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = wd_calc;
            mem_pc_d    = pc;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // An ack arriving on the final wait cycle still completes normally.
        if (mem.mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          done_d     = 1'b1;
          exc_d      = 1'b0;
          exc_code_d = 5'd0;
          rdata_d    = load_val;
        end else if (cnt_q == LAST) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          done_d     = 1'b1;
          exc_d      = 1'b1;
          exc_code_d = 5'd7;
          rdata_d    = 32'd0;
        end
      end
      default: begin
        state_d    = IDLE;
        done_d     = 1'b0;
        exc_d      = 1'b0;
        exc_code_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      done_q      <= 1'b0;
      exc_q       <= 1'b0;
      exc_code_q  <= 5'd0;
      rdata_q     <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_pc_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      done_q      <= done_d;
      exc_q       <= exc_d;
      exc_code_q  <= exc_code_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_pc_q    <= mem_pc_d;
    end
  end

  assign stall         = valid & (state_q != DONE);
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign exc           = exc_q;
  assign exc_code      = exc_code_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_pc    = mem_pc_q;

endmodule
